// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the SRAM-like IF/MEM arbiter: requester ids, lock states, default depth.
package sram_like_arbiter_pkg;
  typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} arb_src_e;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_lock_e;
  localparam int ARB_MAX_OUTST = 4;
endpackage

// File: rtl/sram_like_arbiter_order_fifo.sv
// Issue-order FIFO of requester ids; one entry per accepted request still awaiting data_ok.
module arb_order_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = ARB_MAX_OUTST,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  arb_src_e     din,
  output arb_src_e     head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  cnt
);
  arb_src_e         r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= din;
  end

  assign head  = r_mem[r_rptr];
  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign empty = (r_cnt == '0);
  assign cnt   = r_cnt;
endmodule

// File: rtl/sram_like_arbiter.sv
// Merges IF and MEM SRAM-like ports onto one master port and routes responses in issue order.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise DATA has fixed priority over INST.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = ARB_MAX_OUTST,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err_unexp
);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  arb_lock_e      r_lock;
  arb_src_e       r_lock_src;
  logic           r_err;
  arb_src_e       w_sel, w_grant, w_head;
  logic           w_src_req, w_accept, w_pop, w_full, w_empty;
  logic [CW-1:0]  w_cnt;

`ifdef SRAM_ARB_RR_EN
  arb_src_e r_rr_ptr;

  assign w_sel = (inst_req & data_req) ? r_rr_ptr : (data_req ? SRC_DATA : SRC_INST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_rr_ptr <= SRC_INST;
    else if (w_accept) r_rr_ptr <= (w_grant == SRC_INST) ? SRC_DATA : SRC_INST;
  end
`else
  assign w_sel = data_req ? SRC_DATA : SRC_INST;
`endif

  // A stalled grant stays with its owner until the master takes it
  assign w_grant   = (r_lock == ARB_LOCKED) ? r_lock_src : w_sel;
  assign w_src_req = (w_grant == SRC_DATA) ? data_req : inst_req;
  assign m_req     = w_src_req & ~w_full & ~reset;
  assign w_accept  = m_req & m_addr_ok;

  assign m_wr    = (w_grant == SRC_DATA) ? data_wr    : inst_wr;
  assign m_size  = (w_grant == SRC_DATA) ? data_size  : inst_size;
  assign m_wstrb = (w_grant == SRC_DATA) ? data_wstrb : inst_wstrb;
  assign m_addr  = (w_grant == SRC_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (w_grant == SRC_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = w_accept & (w_grant == SRC_INST);
  assign data_addr_ok = w_accept & (w_grant == SRC_DATA);

  assign w_pop        = m_data_ok & ~reset & (w_cnt != '0);
  assign inst_data_ok = w_pop & (w_head == SRC_INST);
  assign data_data_ok = w_pop & (w_head == SRC_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err_unexp    = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock     <= ARB_IDLE;
      r_lock_src <= SRC_INST;
      r_err      <= 1'b0;
    end else begin
      unique case (r_lock)
        ARB_IDLE: if (m_req & ~m_addr_ok) begin
          r_lock     <= ARB_LOCKED;
          r_lock_src <= w_grant;
        end
        ARB_LOCKED: if (w_accept) r_lock <= ARB_IDLE;
        default: r_lock <= ARB_IDLE;
      endcase
      if (m_data_ok & w_empty) r_err <= 1'b1;
    end
  end

  arb_order_fifo #(.DEPTH(MAX_OUTST)) u_order (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .pop   (w_pop),
    .din   (w_grant),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .cnt   (w_cnt)
  );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed + random bench for sram_like_arbiter against a queue-based transaction model.
module tb_sram_like_arbiter;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, rst;
  logic ireq, iwr, dreq, dwr, maok, mdok;
  logic [1:0] isize, dsize;
  logic [3:0] iwstrb, dwstrb;
  logic [31:0] iaddr, iwdata, daddr, dwdata, mrdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic m_req, m_wr, err_unexp;
  logic [1:0] m_size;
  logic [3:0] m_wstrb;
  logic [31:0] m_addr, m_wdata;

  sram_like_arbiter #(.MAX_OUTST(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(rst),
    .inst_req(ireq), .inst_wr(iwr), .inst_size(isize), .inst_wstrb(iwstrb),
    .inst_addr(iaddr), .inst_wdata(iwdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(dreq), .data_wr(dwr), .data_size(dsize), .data_wstrb(dwstrb),
    .data_addr(daddr), .data_wdata(dwdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(maok), .m_data_ok(mdok), .m_rdata(mrdata),
    .err_unexp(err_unexp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;
  bit q[$];          // ids of accepted requests awaiting data_ok, oldest first
  int owed = -1;     // requester promised the port after a stalled request
  int rr_pref = 0;
  bit err = 1'b0;
  bit e_iaok, e_daok;
  logic o_iaok, o_daok, o_idok, o_ddok, o_mreq;
  logic [31:0] o_maddr, o_rdata;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ireq = 0; dreq = 0; maok = 0; mdok = 0;
    iwr = 0; dwr = 0; isize = 2'd2; dsize = 2'd2; iwstrb = 4'hf; dwstrb = 4'hf;
    iaddr = 0; daddr = 0; iwdata = 0; dwdata = 0; mrdata = 0;
  endtask

  // Called just after a rising edge with inputs set; checks outputs, then advances the model.
  task automatic cyc();
    int src;
    bit req, full, mreq, acc, pop, front;
    #2;
    full = (q.size() == 4);
    if (owed >= 0) begin
      src = owed;
      req = (src == 1) ? dreq : ireq;
    end else begin
      if (ireq && dreq) src = RR ? rr_pref : 1;
      else              src = dreq ? 1 : 0;
      req = ireq | dreq;
    end
    mreq  = req && !full;
    acc   = mreq && maok;
    pop   = mdok && (q.size() > 0);
    front = pop ? q[0] : 1'b0;
    e_iaok = acc && src == 0;
    e_daok = acc && src == 1;
    chk("m_req", m_req, mreq);
    if (mreq)
      chk("m_fields", {m_wr, m_size, m_wstrb, m_addr, m_wdata},
          (src == 1) ? {dwr, dsize, dwstrb, daddr, dwdata} : {iwr, isize, iwstrb, iaddr, iwdata});
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_data_ok", inst_data_ok, pop && front == 1'b0);
    chk("data_data_ok", data_data_ok, pop && front == 1'b1);
    if (pop) chk("rdata", {inst_rdata, data_rdata}, {mrdata, mrdata});
    chk("err_unexp", err_unexp, err);
    o_iaok = inst_addr_ok; o_daok = data_addr_ok; o_idok = inst_data_ok;
    o_ddok = data_data_ok; o_mreq = m_req; o_maddr = m_addr; o_rdata = inst_rdata;
    @(posedge clk);
    if (mdok && q.size() == 0) err = 1'b1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(src[0]);
      owed = -1;
      rr_pref = 1 - src;
    end else if (mreq) owed = src;
    #1;
  endtask

  task automatic do_reset();
    rst = 1; ireq = 1; dreq = 1; maok = 1; mdok = 1;
    #2;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    chk("rst_err", err_unexp, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    idle();
    q.delete(); owed = -1; rr_pref = 0; err = 1'b0;
  endtask

  task automatic drain();
    ireq = 0; dreq = 0; maok = 0; mdok = 1;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      mrdata = $urandom;
      cyc();
    end
    mdok = 0;
  endtask

  initial begin
    bit ip, dp;
    rst = 1; idle();
    @(posedge clk); #1;
    do_reset();

    // both request in IDLE with the master ready
    ireq = 1; dreq = 1; iaddr = 32'h100; daddr = 32'h200; maok = 1;
    cyc();
    chk("both_first", {o_iaok, o_daok}, RR ? 2'b10 : 2'b01);
    if (RR) begin ireq = 0; dreq = 1; end else begin ireq = 1; dreq = 0; end
    cyc();
    chk("both_second", {o_iaok, o_daok}, RR ? 2'b01 : 2'b10);
    drain();

    // stalled INST grant must not be stolen by a later DATA request
    ireq = 1; iaddr = 32'h1000; maok = 0;
    cyc();
    dreq = 1; daddr = 32'h2000;
    cyc();
    cyc();
    chk("lock_addr", o_maddr, 32'h1000);
    chk("lock_no_data", o_daok, 1'b0);
    maok = 1;
    cyc();
    chk("lock_accept", {o_iaok, o_maddr}, {1'b1, 32'h1000});
    ireq = 0;
    cyc();
    chk("lock_then_data", {o_daok, o_maddr}, {1'b1, 32'h2000});
    drain();

    // responses return in issue order
    maok = 1;
    ireq = 1; iaddr = 32'h1000; cyc();
    ireq = 0; dreq = 1; daddr = 32'h2000; cyc();
    dreq = 0; ireq = 1; iaddr = 32'h1004; cyc();
    ireq = 0; maok = 0; mdok = 1;
    mrdata = 32'hAAAA_0001; cyc();
    chk("ord_a", {o_idok, o_ddok, o_rdata}, {2'b10, 32'hAAAA_0001});
    mrdata = 32'hBBBB_0002; cyc();
    chk("ord_b", {o_idok, o_ddok, o_rdata}, {2'b01, 32'hBBBB_0002});
    mrdata = 32'hCCCC_0003; cyc();
    chk("ord_c", {o_idok, o_ddok, o_rdata}, {2'b10, 32'hCCCC_0003});
    mdok = 0;

    // fill to capacity; a same-cycle pop does not reopen the port
    maok = 1;
    for (int k = 0; k < 4; k++) begin
      ireq = (k % 2 == 0); dreq = (k % 2 == 1); cyc();
    end
    ireq = 1; dreq = 1; mdok = 1;
    cyc();
    chk("full_blocked", o_mreq, 1'b0);
    chk("full_pop", o_idok, 1'b1);
    mdok = 0;
    cyc();
    chk("full_resume", o_mreq, 1'b1);
    drain();

    // push and pop together with two outstanding
    maok = 1;
    ireq = 1; dreq = 0; cyc();
    ireq = 0; dreq = 1; cyc();
    ireq = 1; dreq = 0; mdok = 1; cyc();
    chk("pp_pop_head", {o_iaok, o_idok}, 2'b11);
    ireq = 0; maok = 0;
    cyc();
    chk("pp_head_adv", o_ddok, 1'b1);
    cyc();
    chk("pp_last", o_idok, 1'b1);
    chk("pp_empty_after", q.size(), 0);
    mdok = 0;

    // random traffic; requesters hold requests until accepted
    ip = 0; dp = 0;
    for (int n = 0; n < 600; n++) begin
      if (!ip && $urandom_range(2) == 0) begin
        ip = 1; iaddr = $urandom & 32'hffff_fffc; iwdata = $urandom;
        iwr = $urandom_range(1); isize = 2'($urandom_range(2)); iwstrb = 4'($urandom);
      end
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1; daddr = $urandom & 32'hffff_fffc; dwdata = $urandom;
        dwr = $urandom_range(1); dsize = 2'($urandom_range(2)); dwstrb = 4'($urandom);
      end
      ireq = ip; dreq = dp;
      maok = $urandom_range(1);
      mdok = (q.size() > 0) && ($urandom_range(2) != 0);
      mrdata = $urandom;
      cyc();
      if (e_iaok) ip = 0;
      if (e_daok) dp = 0;
    end
    drain();

    // unexpected response sets a sticky error
    idle(); mdok = 1;
    cyc();
    chk("unexp_no_ok", {o_idok, o_ddok}, 2'b00);
    mdok = 0;
    cyc(); cyc();
    chk("unexp_sticky", err_unexp, 1'b1);

    // reset in the middle of a burst with three outstanding
    maok = 1;
    ireq = 1; cyc();
    ireq = 0; dreq = 1; cyc();
    dreq = 0; ireq = 1; cyc();
    do_reset();
    mdok = 1;
    cyc();
    chk("late_no_ok", {o_idok, o_ddok}, 2'b00);
    mdok = 0;
    cyc();
    chk("late_err", err_unexp, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
